expr_vec_driver: RTL and testbench

- Stimulus/response end of the expression-DUT interface: generates pseudo-random operand bundles (a0..a5, b0..b5) for an expression_* block and compacts its 90-bit packed result y into a 32-bit signature.
- Sits in the regression harness between the run controller and the DUT; one instance per DUT.
- The resulting signature is compared against a golden model offline.

---
 rtl/expr_vec_pkg.sv | 66 ++++++
 rtl/expr_vec_driver_if.sv | 34 +++
 rtl/expr_misr32.sv | 35 +++
 rtl/expr_vec_driver.sv | 102 ++++++++++
 tb/tb_expr_vec_driver.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/expr_vec_pkg.sv
// Shared types and constants for the expression-DUT stimulus/response driver.
// Holds the operand/result layouts, LFSR/MISR polynomials and the driver state encoding.
package expr_vec_pkg;

    // Operand field widths. The struct below fixes their order and offsets, MSB first.
    localparam int unsigned A0_W = 4;
    localparam int unsigned A1_W = 5;
    localparam int unsigned A2_W = 6;
    localparam int unsigned A3_W = 4;
    localparam int unsigned A4_W = 5;
    localparam int unsigned A5_W = 6;
    localparam int unsigned B0_W = 4;
    localparam int unsigned B1_W = 5;
    localparam int unsigned B2_W = 6;
    localparam int unsigned B3_W = 4;
    localparam int unsigned B4_W = 5;
    localparam int unsigned B5_W = 6;
    localparam int unsigned VEC_W = A0_W + A1_W + A2_W + A3_W + A4_W + A5_W
                                  + B0_W + B1_W + B2_W + B3_W + B4_W + B5_W;

    // The DUT's y output is 18 fields of 5 bits each.
    localparam int unsigned Y_NUM   = 18;
    localparam int unsigned Y_FLD_W = 5;
    localparam int unsigned RES_W   = Y_NUM * Y_FLD_W;

    localparam int unsigned LFSR_W = 64;
    localparam int unsigned SIG_W  = 32;
    localparam int unsigned CNT_W  = 16;

    // Galois taps for x^64+x^63+x^61+x^60+1 (right-shifting form).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [SIG_W-1:0]  MISR_POLY = 32'h04C1_1DB7;

    typedef struct packed {
        logic [A0_W-1:0] a0;
        logic [A1_W-1:0] a1;
        logic [A2_W-1:0] a2;
        logic [A3_W-1:0] a3;
        logic [A4_W-1:0] a4;
        logic [A5_W-1:0] a5;
        logic [B0_W-1:0] b0;
        logic [B1_W-1:0] b1;
        logic [B2_W-1:0] b2;
        logic [B3_W-1:0] b3;
        logic [B4_W-1:0] b4;
        logic [B5_W-1:0] b5;
    } operand_t;

    typedef logic [Y_NUM-1:0][Y_FLD_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    // Compresses the 90-bit result to 32 bits before it enters the MISR.
    function automatic logic [SIG_W-1:0] misr_fold(input result_t y);
        logic [RES_W-1:0] f;
        f = RES_W'(y);
        return f[31:0] ^ f[63:32] ^ {6'b0, f[89:64]};
    endfunction

endpackage

// File: rtl/expr_vec_driver_if.sv
// Bus between the vector driver, its run controller and the expression DUT.
// master = the driver; slave = the controller/DUT side.
interface expr_vec_driver_if;
    import expr_vec_pkg::*;

    logic               start;
    operand_t           vec_out;
    result_t            res_in;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   vec_cnt;
    logic [SIG_W-1:0]   signature;

    modport master (
        input  start,
        input  res_in,
        output vec_out,
        output busy,
        output done,
        output vec_cnt,
        output signature
    );

    modport slave (
        output start,
        output res_in,
        input  vec_out,
        input  busy,
        input  done,
        input  vec_cnt,
        input  signature
    );

endinterface

// File: rtl/expr_misr32.sv
// 32-bit MISR compacting the folded 90-bit DUT result.
// load restarts from SIG_INIT; en performs one shift/fold step.
module expr_misr32
    import expr_vec_pkg::*;
#(
    parameter logic [SIG_W-1:0] SIG_INIT = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  result_t          res_in,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_next_c;

    always_comb begin
        sig_next_c = {sig[SIG_W-2:0], 1'b0} ^ misr_fold(res_in);
        if (sig[SIG_W-1]) begin
            sig_next_c = sig_next_c ^ MISR_POLY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SIG_INIT;
        end else if (load) begin
            sig <= SIG_INIT;
        end else if (en) begin
            sig <= sig_next_c;
        end
    end

endmodule

// File: rtl/expr_vec_driver.sv
// Drives LFSR-generated operand vectors into an expression DUT and compacts
// each sampled result into a MISR signature; one run = NUM_VEC vectors.
module expr_vec_driver
    import expr_vec_pkg::*;
#(
    parameter int unsigned       NUM_VEC  = 256,
    parameter logic [LFSR_W-1:0] SEED     = 64'h0000_0000_0000_0001,
    parameter int unsigned       DUT_LAT  = 0,
    parameter logic [SIG_W-1:0]  SIG_INIT = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    expr_vec_driver_if.master bus
);

    localparam logic [1:0]       WAIT_LAST = 2'(DUT_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_VEC);

    state_t             state;
    logic [LFSR_W-1:0]  lfsr;
    logic [LFSR_W-1:0]  lfsr_next_c;
    logic [1:0]         wait_cnt;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               start_ok_c;
    logic               misr_en_c;

    assign lfsr_next_c = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);

    // A start pulse is honoured only when no run is in flight.
    assign start_ok_c = bus.start && ((state == IDLE) || (state == DONE));
    assign misr_en_c  = (state == SAMPLE);

    // Run sequencing. LOAD-state initialisation is applied on the accepting edge
    // so the LOAD cycle already shows the restarted count and signature.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= SEED;
            wait_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok_c) begin
                        state    <= LOAD;
                        lfsr     <= SEED;
                        wait_cnt <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                LOAD: begin
                    state <= DRIVE;
                end
                DRIVE: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                SAMPLE: begin
                    lfsr  <= lfsr_next_c;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == CNT_LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= DRIVE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    expr_misr32 #(
        .SIG_INIT (SIG_INIT)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_ok_c),
        .en     (misr_en_c),
        .res_in (bus.res_in),
        .sig    (bus.signature)
    );

    assign bus.vec_out = operand_t'(lfsr[VEC_W-1:0]);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.vec_cnt = cnt_q;

endmodule

// File: tb/tb_expr_vec_driver.sv
// Bench for expr_vec_driver: two instances (1 vector/latency 0, 4 vectors/latency 2)
// checked every cycle against a run-position model plus literal expectations.
module tb_expr_vec_driver;

    localparam int unsigned N1 = 1;
    localparam int unsigned L1 = 0;
    localparam int unsigned N4 = 4;
    localparam int unsigned L4 = 2;
    localparam int          P1 = 2 + L1;
    localparam int          P4 = 2 + L4;
    localparam logic [63:0] SEED  = 64'h0000_0000_0000_0001;
    localparam logic [31:0] SINIT = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;

    expr_vec_driver_if if1();
    expr_vec_driver_if if4();

    expr_vec_driver #(.NUM_VEC(N1), .SEED(SEED), .DUT_LAT(L1), .SIG_INIT(SINIT)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.master)
    );

    expr_vec_driver #(.NUM_VEC(N4), .SEED(SEED), .DUT_LAT(L4), .SIG_INIT(SINIT)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.master)
    );

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in expression DUT: y = {hi*lo, hi^lo} over the two 30-bit operand halves.
    function automatic logic [89:0] ref_y(input logic [59:0] v);
        logic [59:0] p;
        p = 60'(v[59:30]) * 60'(v[29:0]);
        return {p, v[59:30] ^ v[29:0]};
    endfunction

    function automatic logic [63:0] lfsr_step(input logic [63:0] x);
        logic [63:0] n;
        n = x >> 1;
        if (x[0]) n = n ^ 64'hD800_0000_0000_0000;
        return n;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [89:0] r);
        logic [31:0] fold;
        logic [31:0] n;
        fold = r[31:0] ^ r[63:32] ^ {6'b0, r[89:64]};
        n = (s << 1) ^ fold;
        if (s[31]) n = n ^ 32'h04C1_1DB7;
        return n;
    endfunction

    // Expected outputs from run position: c cycles after the accepting edge.
    task automatic model_out(input bit run, input int c, input int n, input int per,
                             input bit use_ref, output logic [59:0] ev, output logic [31:0] es,
                             output logic eb, output logic ed, output logic [15:0] ecnt);
        logic [63:0] l;
        logic [31:0] s;
        int m;
        l = SEED;
        s = SINIT;
        if (!run) begin
            eb = 1'b0;
            ed = 1'b0;
            m  = 0;
        end else begin
            m = (c == 0) ? 0 : (c - 1) / per;
            if (m > n) m = n;
            eb = (c < 1 + n * per);
            ed = !eb;
        end
        for (int j = 0; j < m; j++) begin
            s = misr_step(s, use_ref ? ref_y(l[59:0]) : 90'd0);
            l = lfsr_step(l);
        end
        ev   = l[59:0];
        es   = s;
        ecnt = 16'(m);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference DUT with two pipeline stages for the latency-2 instance.
    logic [89:0] y4_d1, y4_d2;
    always @(posedge clk) begin
        y4_d1 <= ref_y(if4.vec_out);
        y4_d2 <= y4_d1;
    end
    assign if4.res_in = y4_d2;
    assign if1.res_in = '0;

    // Run-position tracking: a start is taken only when the model says not busy.
    bit run1, run4;
    int c1, c4;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run1 <= 1'b0; c1 <= 0;
            run4 <= 1'b0; c4 <= 0;
        end else begin
            if (if1.start && !(run1 && c1 < 1 + int'(N1) * P1)) begin
                run1 <= 1'b1; c1 <= 0;
            end else if (run1) begin
                c1 <= c1 + 1;
            end
            if (if4.start && !(run4 && c4 < 1 + int'(N4) * P4)) begin
                run4 <= 1'b1; c4 <= 0;
            end else if (run4) begin
                c4 <= c4 + 1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [59:0] ev;
        logic [31:0] es;
        logic        eb, ed;
        logic [15:0] ecnt;
        model_out(run1, c1, N1, P1, 1'b0, ev, es, eb, ed, ecnt);
        chk("cyc.dut1.vec_out",   64'(if1.vec_out),   64'(ev));
        chk("cyc.dut1.signature", 64'(if1.signature), 64'(es));
        chk("cyc.dut1.busy",      64'(if1.busy),      64'(eb));
        chk("cyc.dut1.done",      64'(if1.done),      64'(ed));
        chk("cyc.dut1.vec_cnt",   64'(if1.vec_cnt),   64'(ecnt));
        model_out(run4, c4, N4, P4, 1'b1, ev, es, eb, ed, ecnt);
        chk("cyc.dut4.vec_out",   64'(if4.vec_out),   64'(ev));
        chk("cyc.dut4.signature", 64'(if4.signature), 64'(es));
        chk("cyc.dut4.busy",      64'(if4.busy),      64'(eb));
        chk("cyc.dut4.done",      64'(if4.done),      64'(ed));
        chk("cyc.dut4.vec_cnt",   64'(if4.vec_cnt),   64'(ecnt));
    end

    task automatic pulse(input bit which4);
        if (which4) if4.start = 1'b1; else if1.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_done4(input int from_c, output int cyc);
        cyc = from_c;
        while (!if4.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".vec_out"},   64'(if4.vec_out),   64'h1);
        chk({tag, ".signature"}, 64'(if4.signature), 64'hFFFF_FFFF);
        chk({tag, ".busy"},      64'(if4.busy),      64'h0);
        chk({tag, ".done"},      64'(if4.done),      64'h0);
        chk({tag, ".vec_cnt"},   64'(if4.vec_cnt),   64'h0);
    endtask

    initial begin
        logic [59:0] ev;
        logic [31:0] es, exp_sig4;
        logic        eb, ed;
        logic [15:0] ecnt;
        int nb, cyc;

        rst_n     = 1'b0;
        if1.start = 1'b0;
        if4.start = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_vals("reset.dut4");
        chk("reset.dut1.vec_out",   64'(if1.vec_out),   64'h1);
        chk("reset.dut1.signature", 64'(if1.signature), 64'hFFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Model pins against hand-computed values.
        chk("model.lfsr_step1", lfsr_step(64'h1), 64'hD800_0000_0000_0000);
        model_out(1'b1, 3, 1, 2, 1'b0, ev, es, eb, ed, ecnt);
        chk("model.sig_n1_zero", 64'(es), 64'hFB3E_E249);
        model_out(1'b1, 17, N4, P4, 1'b1, ev, exp_sig4, eb, ed, ecnt);

        // Single vector, combinational DUT, res_in = 0.
        pulse(1'b0);
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (!if1.busy) break;
            nb++;
            @(negedge clk);
        end
        chk("n1.busy_cycles", 64'(nb), 64'd3);
        chk("n1.done",        64'(if1.done),      64'h1);
        chk("n1.vec_cnt",     64'(if1.vec_cnt),   64'h1);
        chk("n1.signature",   64'(if1.signature), 64'hFB3E_E249);
        chk("n1.vec_out",     64'(if1.vec_out),   64'h0800_0000_0000_0000);

        // Four vectors, latency 2: clean run.
        pulse(1'b1);
        wait_done4(0, cyc);
        chk("n4.run_len",   64'(cyc), 64'd17);
        chk("n4.vec_cnt",   64'(if4.vec_cnt),   64'd4);
        chk("n4.signature", 64'(if4.signature), 64'(exp_sig4));

        // Restart from DONE reproduces the signature.
        pulse(1'b1);
        chk("rerun.load_sig", 64'(if4.signature), 64'hFFFF_FFFF);
        chk("rerun.load_cnt", 64'(if4.vec_cnt),   64'h0);
        wait_done4(0, cyc);
        chk("rerun.run_len",   64'(cyc), 64'd17);
        chk("rerun.signature", 64'(if4.signature), 64'(exp_sig4));

        // Start pulse during DRIVE of vector 2 must be ignored.
        pulse(1'b1);
        repeat (6) @(negedge clk);
        pulse(1'b1);
        wait_done4(7, cyc);
        chk("busy_start.run_len",   64'(cyc), 64'd17);
        chk("busy_start.vec_cnt",   64'(if4.vec_cnt),   64'd4);
        chk("busy_start.signature", 64'(if4.signature), 64'(exp_sig4));

        // Reset during SAMPLE of vector 3, then a clean run.
        pulse(1'b1);
        repeat (12) @(negedge clk);
        chk("abort.pre_cnt", 64'(if4.vec_cnt), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_vals("abort.async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(1'b1);
        wait_done4(0, cyc);
        chk("abort.rerun_len",       64'(cyc), 64'd17);
        chk("abort.rerun_signature", 64'(if4.signature), 64'(exp_sig4));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
